prio_arbiter_n: RTL and testbench

PRIO_ARBITER_N -- requirements
Module: prio_arbiter_n

---
 rtl/prio_arbiter_n.sv | 102 ++++++++++
 tb/tb_prio_arbiter_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_n.sv
// rtl/prio_arbiter_n.sv - N-way arbiter with fixed-priority and round-robin modes
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[N]      request vector, bit i = requester i wants the resource
//   mode        0 = fixed priority (highest index wins), 1 = round-robin
//   ack         consumer accepts the active grant (ignored while idle)
//   gnt_valid   a grant is active
//   gnt_idx[W]  binary index of the granted requester (holds after release)
//   gnt_onehot  one-hot grant while gnt_valid, else zero
module prio_arbiter_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [N-1:0] ONE_N = N'(1);

  logic [0:0]   state;
  logic [W-1:0] ptr;

  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [W-1:0] rot_idx;
  int           rot;

  // Fixed priority: ascending scan so the last (highest) set bit wins.
  // Round-robin: descending scan over the rotated order so the set bit
  // closest to ptr (searching upward with wrap) is the final assignment.
  always_comb begin
    fixed_idx = '0;
    rr_idx    = '0;
    rot       = 0;
    rot_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fixed_idx = W'(i);
    end
    for (int k = N - 1; k >= 0; k--) begin
      rot = int'(ptr) + k;
      if (rot >= N) rot = rot - N;
      rot_idx = W'(rot);
      if (req[rot_idx]) rr_idx = rot_idx;
    end
    win_idx = mode ? rr_idx : fixed_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= win_idx;
            gnt_onehot <= ONE_N << win_idx;
          end
        end
        GRANT: begin
          // ack takes precedence over a simultaneous withdrawal so the
          // pointer still advances past the served requester.
          if (ack) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            if (mode) begin
              ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
            end
          end else if (!req[gnt_idx]) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter_n.sv
// tb/tb_prio_arbiter_n.sv - self-checking bench for prio_arbiter_n
module tb_prio_arbiter_n;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  int n_checks;
  int n_pass;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  prio_arbiter_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .ack       (ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_onehot(gnt_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // highest set bit = floor(log2(r))
  function automatic int fixed_win(input logic [N-1:0] r);
    return $clog2(longint'(r) + 1) - 1;
  endfunction

  function automatic int rr_win(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_onehot();
    logic [N-1:0] v;
    v = '0;
    if (m_valid) v[m_idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  // Advance one clock (inputs already set at a negedge) and update the model;
  // returns at the following negedge, where outputs are sampled.
  task automatic cycle();
    if (!m_valid) begin
      if (req != 0) begin
        m_idx   = mode ? rr_win(req, m_ptr) : fixed_win(req);
        m_valid = 1;
      end
    end else if (ack) begin
      m_valid = 0;
      if (mode) m_ptr = (m_idx + 1) % N;
    end else if (!req[m_idx]) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    mode  = 1'b0;
    ack   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", gnt_valid);
    else n_pass++;
    n_checks++;
    if (gnt_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", gnt_idx);
    else n_pass++;
    n_checks++;
    if (gnt_onehot !== 8'h00) $display("FAIL reset_onehot: got %h want 00", gnt_onehot);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; req = 8'b0010_1010; ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_checks++;
      if (gnt_valid !== (c % 2 == 0)) $display("FAIL fixed_valid c%0d: got %b want %b", c, gnt_valid, (c % 2 == 0));
      else n_pass++;
      n_checks++;
      if (gnt_idx !== 3'd5) $display("FAIL fixed_idx c%0d: got %0d want 5", c, gnt_idx);
      else n_pass++;
      n_checks++;
      if (gnt_onehot !== ((c % 2 == 0) ? 8'h20 : 8'h00))
        $display("FAIL fixed_onehot c%0d: got %h want %h", c, gnt_onehot, (c % 2 == 0) ? 8'h20 : 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_rr_rotation();
    do_reset();
    mode = 1'b1; req = 8'hFF; ack = 1'b1;
    for (int c = 0; c < 18; c++) begin
      cycle();
      n_checks++;
      if (gnt_valid !== (c % 2 == 0)) $display("FAIL rr_valid c%0d: got %b want %b", c, gnt_valid, (c % 2 == 0));
      else n_pass++;
      if (c % 2 == 0) begin
        n_checks++;
        if (int'(gnt_idx) != (c / 2) % 8) $display("FAIL rr_idx c%0d: got %0d want %0d", c, gnt_idx, (c / 2) % 8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    mode = 1'b1; req = 8'h20; ack = 1'b1;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd5 || gnt_valid !== 1'b1) $display("FAIL sparse_first: got v%b idx %0d want v1 idx 5", gnt_valid, gnt_idx);
    else n_pass++;
    req = 8'b0000_0101;
    cycle();
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) $display("FAIL sparse_wrap0: got v%b idx %0d want v1 idx 0", gnt_valid, gnt_idx);
    else n_pass++;
    cycle();
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) $display("FAIL sparse_next2: got v%b idx %0d want v1 idx 2", gnt_valid, gnt_idx);
    else n_pass++;
  endtask

  task automatic test_withdraw();
    do_reset();
    mode = 1'b1; req = 8'h08; ack = 1'b0;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) $display("FAIL wd_grant: got v%b idx %0d want v1 idx 3", gnt_valid, gnt_idx);
    else n_pass++;
    // mode flip and a new higher request must not disturb the active grant
    mode = 1'b0; req = 8'h88;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd3 || gnt_onehot !== 8'h08 || gnt_valid !== 1'b1)
      $display("FAIL wd_hold: got v%b idx %0d oh %h want v1 idx 3 oh 08", gnt_valid, gnt_idx, gnt_onehot);
    else n_pass++;
    mode = 1'b1; req = 8'h81;
    cycle();
    n_checks++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00 || gnt_idx !== 3'd3)
      $display("FAIL wd_drop: got v%b idx %0d oh %h want v0 idx 3 oh 00", gnt_valid, gnt_idx, gnt_onehot);
    else n_pass++;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) $display("FAIL wd_ptr_kept: got v%b idx %0d want v1 idx 0", gnt_valid, gnt_idx);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; req = 8'h10; ack = 1'b0;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd4 || gnt_valid !== 1'b1) $display("FAIL ar_grant: got v%b idx %0d want v1 idx 4", gnt_valid, gnt_idx);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h00)
      $display("FAIL ar_immediate: got v%b idx %0d oh %h want v0 idx 0 oh 00", gnt_valid, gnt_idx, gnt_onehot);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (gnt_idx !== 3'd4 || gnt_valid !== 1'b1 || gnt_onehot !== 8'h10)
      $display("FAIL ar_after: got v%b idx %0d oh %h want v1 idx 4 oh 10", gnt_valid, gnt_idx, gnt_onehot);
    else n_pass++;
  endtask

  task automatic test_fixed_sweep();
    do_reset();
    mode = 1'b0; ack = 1'b1;
    for (int r = 0; r < 256; r++) begin
      req = N'(r);
      cycle();
      n_checks++;
      if (gnt_valid !== (r != 0)) $display("FAIL sweep_valid r%0d: got %b want %b", r, gnt_valid, (r != 0));
      else n_pass++;
      if (r != 0) begin
        n_checks++;
        if (int'(gnt_idx) != $clog2(r + 1) - 1) $display("FAIL sweep_idx r%0d: got %0d want %0d", r, gnt_idx, $clog2(r + 1) - 1);
        else n_pass++;
      end
      cycle();
      n_checks++;
      if (gnt_valid !== 1'b0) $display("FAIL sweep_release r%0d: got %b want 0", r, gnt_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      else req = N'($urandom) & N'($urandom) & N'($urandom);
      mode = 1'($urandom);
      ack  = ($urandom_range(0, 2) != 0);
      cycle();
      n_checks++;
      if (gnt_valid !== m_valid || (m_valid && int'(gnt_idx) != m_idx) || gnt_onehot !== m_onehot())
        $display("FAIL random c%0d: got v%b idx %0d oh %h want v%b idx %0d oh %h",
                 c, gnt_valid, gnt_idx, gnt_onehot, m_valid, m_idx, m_onehot());
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    req      = '0;
    mode     = 1'b0;
    ack      = 1'b0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_sparse_wrap();
    test_withdraw();
    test_async_reset();
    test_fixed_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
